// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline: latches the decoded control
// bundle and operands, and inserts a bubble on a load-use hazard against EX.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              id_valid,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,

  input  logic              stall,
  input  logic              flush,

  output logic              hazard_stall,

  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd
);

  logic rt_dep;
  logic load_use;

  // A load into $0 never produces a value anyone waits for.
  assign rt_dep   = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));
  assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid & rt_dep;

  // Under an external hold or a flush the stage is not advancing, so no bubble is needed.
  assign hazard_stall = load_use & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= '0;
      ex_pc4        <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
    end else if (flush || (!stall && hazard_stall)) begin
      ex_valid      <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op     <= '0;
      ex_pc4        <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
    end else if (!stall) begin
      // Controls are qualified by id_valid so an empty ID slot enters EX as a bubble.
      ex_valid      <= id_valid;
      ex_reg_dst    <= id_reg_dst & id_valid;
      ex_branch     <= id_branch & id_valid;
      ex_mem_read   <= id_mem_read & id_valid;
      ex_mem_to_reg <= id_mem_to_reg & id_valid;
      ex_mem_write  <= id_mem_write & id_valid;
      ex_alu_src    <= id_alu_src & id_valid;
      ex_reg_write  <= id_reg_write & id_valid;
      ex_alu_op     <= id_alu_op & {2{id_valid}};
      ex_pc4        <= id_pc4;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= id_imm;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
    end
  end

endmodule
